// File: rtl/mem_access_if.sv
// Byte-wide memory port shared with instruction fetch.
// The MEM stage is the master; the arbiter is the slave.
interface mem_access_if;
   logic        mem_req_o;
   logic        mem_wr_o;
   logic [31:0] mem_a_o;
   logic [7:0]  mem_dout_o;
   logic        mem_gnt_i;
   logic [7:0]  mem_din_i;

   modport master (
      output mem_req_o,
      output mem_wr_o,
      output mem_a_o,
      output mem_dout_o,
      input  mem_gnt_i,
      input  mem_din_i
   );

   modport slave (
      input  mem_req_o,
      input  mem_wr_o,
      input  mem_a_o,
      input  mem_dout_o,
      output mem_gnt_i,
      output mem_din_i
   );
endinterface

// File: rtl/mem_access.sv
// MEM stage: byte-serial loads/stores over the shared 8-bit port.
// Stalls the pipeline while an access is in flight.
module mem_access (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic [4:0]   ex_wd,
   input  logic         ex_wreg,
   input  logic [31:0]  ex_wdata,
   input  logic [3:0]   ex_mem_op,
   input  logic [31:0]  ex_mem_addr,
   input  logic [31:0]  ex_mem_sdata,
   output logic [4:0]   mem_wd,
   output logic         mem_wreg,
   output logic [31:0]  mem_wdata,
   output logic         mem_stallreq,
   mem_access_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_LAST,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] buf_q, buf_d;
   logic        pend_q, pend_d;
   logic [1:0]  pidx_q, pidx_d;

   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic [1:0]  last_idx;
   logic [31:0] ld_val;
   logic [7:0]  sbyte;
   logic        req;
   logic        gnt_ok;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      last_idx = 2'd0;
      unique case (ex_mem_op)
         4'd1: is_load = 1'b1;
         4'd2: begin
            is_load  = 1'b1;
            last_idx = 2'd1;
         end
         4'd3: begin
            is_load  = 1'b1;
            last_idx = 2'd3;
         end
         4'd4: is_load = 1'b1;
         4'd5: begin
            is_load  = 1'b1;
            last_idx = 2'd1;
         end
         4'd6: is_store = 1'b1;
         4'd7: begin
            is_store = 1'b1;
            last_idx = 2'd1;
         end
         4'd8: begin
            is_store = 1'b1;
            last_idx = 2'd3;
         end
         default: ;
      endcase
   end

   assign is_mem = is_load | is_store;

   always_comb begin
      ld_val = buf_q;
      unique case (ex_mem_op)
         4'd1: ld_val = {{24{buf_q[7]}}, buf_q[7:0]};
         4'd2: ld_val = {{16{buf_q[15]}}, buf_q[15:0]};
         4'd4: ld_val = {24'd0, buf_q[7:0]};
         4'd5: ld_val = {16'd0, buf_q[15:0]};
         default: ld_val = buf_q;
      endcase
   end

   assign sbyte  = ex_mem_sdata[{cnt_q, 3'b000} +: 8];
   assign gnt_ok = req & bus.mem_gnt_i;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      buf_d        = buf_q;
      pend_d       = pend_q;
      pidx_d       = pidx_q;
      req          = 1'b0;
      mem_stallreq = 1'b0;
      mem_wd       = ex_wd;
      mem_wreg     = ex_wreg;
      mem_wdata    = ex_wdata;

      if (is_mem) begin
         mem_wreg  = 1'b0;
         mem_wdata = 32'd0;
      end

      // Read byte lands one cycle after its grant, whatever the state.
      if (pend_q) begin
         buf_d[{pidx_q, 3'b000} +: 8] = bus.mem_din_i;
         pend_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (is_mem) begin
               mem_stallreq = 1'b1;
               cnt_d        = 2'd0;
               state_d      = S_BUSY;
            end
         end
         S_BUSY: begin
            mem_stallreq = is_mem;
            req          = rdy & is_mem;
            if (!is_mem) begin
               state_d = S_IDLE;
            end else if (gnt_ok) begin
               cnt_d = cnt_q + 2'd1;
               if (is_load) begin
                  pend_d = 1'b1;
                  pidx_d = cnt_q;
               end
               if (cnt_q == last_idx) begin
                  state_d = is_store ? S_DONE : S_LAST;
               end
            end
         end
         S_LAST: begin
            mem_stallreq = 1'b1;
            state_d      = S_DONE;
         end
         S_DONE: begin
            if (is_load) begin
               mem_wreg  = ex_wreg;
               mem_wdata = ld_val;
            end
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.mem_req_o  = req;
   assign bus.mem_wr_o   = req & is_store;
   assign bus.mem_a_o    = req ? ex_mem_addr + {30'd0, cnt_q} : 32'd0;
   assign bus.mem_dout_o = req ? sbyte : 8'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         buf_q   <= 32'd0;
         pend_q  <= 1'b0;
         pidx_q  <= 2'd0;
      end else if (rdy) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         pend_q  <= pend_d;
         pidx_q  <= pidx_d;
      end
   end

endmodule
